// File: rtl/calc1_pkg.sv
// calc1 port shared types: command/response codes and the queued request.
// The LSH/RSH shifter is built only when CALC1_SHIFT_EN is defined.
package calc1_pkg;

  typedef enum logic [3:0] {
    CMD_NOP = 4'd0,
    CMD_ADD = 4'd1,
    CMD_SUB = 4'd2,
    CMD_LSH = 4'd5,
    CMD_RSH = 4'd6
  } calc1_cmd_e;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_OK   = 2'd1,
    RESP_ERR  = 2'd2
  } calc1_resp_e;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [31:0] op1;
    logic [31:0] op2;
  } calc1_req_t;

endpackage

// File: rtl/calc1_port_responder_if.sv
// calc1 request/response port as seen between a driver and the responder.
// pop_stall is a testpoint that freezes the execute stage.
interface calc1_port_responder_if;
  logic [3:0]  req_cmd_in;
  logic [31:0] req_data_in;
  logic        pop_stall;
  logic [1:0]  out_resp;
  logic [31:0] out_data;
  logic        req_drop;

  modport master (
    output req_cmd_in,
    output req_data_in,
    output pop_stall,
    input  out_resp,
    input  out_data,
    input  req_drop
  );

  modport slave (
    input  req_cmd_in,
    input  req_data_in,
    input  pop_stall,
    output out_resp,
    output out_data,
    output req_drop
  );
endinterface

// File: rtl/calc1_req_fifo.sv
// Synchronous request FIFO with extra-MSB pointers for full/empty.
// A pop in the same cycle frees a slot for a push into a full FIFO.
module calc1_req_fifo
  import calc1_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  calc1_req_t wdata,
  input  logic       pop,
  output calc1_req_t rdata,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  calc1_req_t    mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW])
              && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/calc1_port_responder.sv
// calc1 port responder: two-cycle capture FSM, request FIFO, ALU.
// Define CALC1_SHIFT_EN to build LSH/RSH; otherwise codes 5/6 are invalid.
module calc1_port_responder
  import calc1_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                   c_clk,
  input  logic                   reset,
  calc1_port_responder_if.slave  bus
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] OPND2 = 1'b1;

  logic [0:0]  state;
  logic [3:0]  cmd_q;
  logic [31:0] op1_q;

  logic        push;
  logic        pop;
  logic        full;
  logic        empty;
  calc1_req_t  push_req;
  calc1_req_t  head;

  calc1_resp_e resp_d;
  logic [31:0] data_d;
  logic [32:0] sum;

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cmd_q <= '0;
      op1_q <= '0;
    end else if (state == IDLE) begin
      if (bus.req_cmd_in != CMD_NOP) begin
        cmd_q <= bus.req_cmd_in;
        op1_q <= bus.req_data_in;
        state <= OPND2;
      end
    end else begin
      state <= IDLE;
    end
  end

  // Operand 2 is taken straight off the bus in the push cycle.
  assign push     = (state == OPND2);
  assign push_req = '{cmd: cmd_q, op1: op1_q, op2: bus.req_data_in};
  assign pop      = !empty && !bus.pop_stall;

  calc1_req_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (c_clk),
    .rst_n (reset),
    .push  (push),
    .wdata (push_req),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    resp_d = RESP_ERR;
    data_d = '0;
    sum    = {1'b0, head.op1} + {1'b0, head.op2};
    unique case (1'b1)
      (head.cmd == CMD_ADD): begin
        if (!sum[32]) begin
          resp_d = RESP_OK;
          data_d = sum[31:0];
        end
      end
      (head.cmd == CMD_SUB): begin
        if (head.op2 <= head.op1) begin
          resp_d = RESP_OK;
          data_d = head.op1 - head.op2;
        end
      end
`ifdef CALC1_SHIFT_EN
      (head.cmd == CMD_LSH): begin
        resp_d = RESP_OK;
        data_d = head.op1 << head.op2[4:0];
      end
      (head.cmd == CMD_RSH): begin
        resp_d = RESP_OK;
        data_d = head.op1 >> head.op2[4:0];
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      bus.out_resp <= RESP_NONE;
      bus.out_data <= '0;
      bus.req_drop <= 1'b0;
    end else begin
      bus.out_resp <= pop ? resp_d : RESP_NONE;
      bus.out_data <= pop ? data_d : '0;
      bus.req_drop <= push && full && !pop;
    end
  end

endmodule

// File: tb/tb_calc1_port_responder.sv
// Scoreboard bench for calc1_port_responder against an arithmetic model.
// Honours CALC1_SHIFT_EN the same way as the design build.
module tb_calc1_port_responder;
  import calc1_pkg::*;

  logic c_clk = 1'b0;
  logic reset = 1'b0;
  always #5 c_clk = ~c_clk;

  calc1_port_responder_if bus ();

  calc1_port_responder #(
    .FIFO_DEPTH (2)
  ) dut (
    .c_clk (c_clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  int   errors    = 0;
  int   checks    = 0;
  int   cyc       = 0;
  int   drops     = 0;
  int   exp_drops = 0;

  always @(posedge c_clk) cyc <= cyc + 1;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic void ref_model(input  logic [3:0]  c,
                                    input  logic [31:0] a,
                                    input  logic [31:0] b,
                                    output logic [1:0]  r,
                                    output logic [31:0] d);
    logic [63:0] s;
    r = 2'd2;
    d = '0;
    s = {32'd0, a} + {32'd0, b};
    if (c == 4'd1 && s < 64'h1_0000_0000) begin
      r = 2'd1;
      d = s[31:0];
    end
    if (c == 4'd2 && b <= a) begin
      r = 2'd1;
      d = a - b;
    end
`ifdef CALC1_SHIFT_EN
    if (c == 4'd5) begin
      r = 2'd1;
      d = a << (b % 32);
    end
    if (c == 4'd6) begin
      r = 2'd1;
      d = a >> (b % 32);
    end
`endif
  endfunction

  // Monitor: every nonzero response must match the oldest expectation.
  always @(posedge c_clk) begin
    #1;
    if (bus.req_drop === 1'b1) drops++;
    if (bus.out_resp !== 2'd0) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got resp %0d data %h expected none",
                 bus.out_resp, bus.out_data);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("resp", {30'd0, bus.out_resp}, {30'd0, e.resp});
        check("data", bus.out_data, e.data);
        if (e.cyc >= 0) check("latency", cyc, e.cyc);
      end
    end
  end

  task automatic send(input logic [3:0]  c,
                      input logic [31:0] a,
                      input logic [31:0] b,
                      input bit          expect_it,
                      input bit          timed,
                      input bit          release_stall);
    int t;
    logic [1:0]  r;
    logic [31:0] d;
    @(negedge c_clk);
    bus.req_cmd_in  = c;
    bus.req_data_in = a;
    t = cyc;
    @(negedge c_clk);
    bus.req_cmd_in  = 4'($urandom_range(15, 0));
    bus.req_data_in = b;
    if (release_stall) bus.pop_stall = 1'b0;
    if (expect_it) begin
      ref_model(c, a, b, r, d);
      sbq.push_back('{resp: r, data: d, cyc: timed ? t + 3 : -1});
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge c_clk);
      bus.req_cmd_in = 4'd0;
    end
  endtask

  task automatic drain(input string name);
    idle(1);
    for (int i = 0; i < 40 && sbq.size() != 0; i++) @(negedge c_clk);
    idle(3);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL %s: got %0d pending responses expected 0",
               name, sbq.size());
      sbq.delete();
    end
  endtask

  initial begin
    bus.req_cmd_in  = 4'd0;
    bus.req_data_in = '0;
    bus.pop_stall   = 1'b0;
    repeat (3) @(negedge c_clk);
    check("reset_resp", {30'd0, bus.out_resp}, 32'd0);
    check("reset_data", bus.out_data, 32'd0);
    check("reset_drop", {31'd0, bus.req_drop}, 32'd0);
    reset = 1'b1;
    idle(2);

    send(4'd1, 32'hFFFF0000, 32'h0000FFFF, 1, 1, 0);
    send(4'd1, 32'hFFFFFFFF, 32'h00000001, 1, 1, 0);
    send(4'd2, 32'h00000000, 32'h00000001, 1, 1, 0);
    send(4'd2, 32'hFFFF0000, 32'h0000FFFF, 1, 1, 0);
    send(4'd2, 32'h12345678, 32'h12345678, 1, 1, 0);
    send(4'd5, 32'h0F0F0F0F, 32'd4,        1, 1, 0);
    send(4'd6, 32'h80000000, 32'd31,       1, 1, 0);
    send(4'd5, 32'h00000001, 32'd32,       1, 1, 0);
    send(4'd5, 32'hFFFFFFFF, 32'd32,       1, 1, 0);
    send(4'd6, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1, 0);
    send(4'd3, 32'h00001234, 32'h00005678, 1, 1, 0);
    send(4'd1, 32'd1,        32'd1,        1, 1, 0);
    drain("directed_drain");

    for (int i = 0; i < 150; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = $urandom;
      b = $urandom;
      if ($urandom_range(3, 0) == 0) b = b % 40;
      if ($urandom_range(3, 0) == 0) a = a % 16;
      send(4'($urandom_range(15, 1)), a, b, 1, 1, 0);
      idle($urandom_range(2, 0));
    end
    drain("random_drain");
    check("random_no_drop", drops, exp_drops);

    // Stalled execute: two requests fill the FIFO, the third is dropped.
    @(negedge c_clk);
    bus.req_cmd_in = 4'd0;
    bus.pop_stall  = 1'b1;
    send(4'd1, 32'd10, 32'd20, 1, 0, 0);
    send(4'd2, 32'd50, 32'd8,  1, 0, 0);
    send(4'd1, 32'd7,  32'd7,  0, 0, 0);
    exp_drops++;
    idle(3);
    check("drop_on_third", drops, exp_drops);
    // Push into the full FIFO in the same cycle the stall is lifted.
    send(4'd1, 32'd100, 32'd23, 1, 0, 1);
    drain("stall_drain");
    check("no_drop_on_push_pop", drops, exp_drops);

    // Reset between command and operand-2 cycles discards the request.
    @(negedge c_clk);
    bus.req_cmd_in  = 4'd1;
    bus.req_data_in = 32'd7;
    @(negedge c_clk);
    reset           = 1'b0;
    bus.req_cmd_in  = 4'd0;
    bus.req_data_in = 32'd9;
    #1;
    check("midreq_reset_resp", {30'd0, bus.out_resp}, 32'd0);
    idle(2);
    reset = 1'b1;
    idle(1);
    send(4'd1, 32'd2, 32'd3, 1, 1, 0);
    drain("reset_drain");
    check("final_drops", drops, exp_drops);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/calc1_port_responder.md
# calc1_port_responder

- Responder end of one calc1 request port: the block that answers the requests a port driver issues.
- Captures a two-cycle request (command plus operand 1, then operand 2), queues completed requests, executes ADD/SUB/LSH/RSH, and returns a one-cycle response code with result data.
- Instantiated once per port (1–4) as the reference model behind the calc1 bench, and as the port engine of the calculator datapath.

## Interface
- `FIFO_DEPTH`, default 2: completed requests held awaiting execution; must be a power of two, ≥2.
- `c_clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-low.
- `req_cmd_in` in 4: command; 0 NOP, 1 ADD, 2 SUB, 5 LSH, 6 RSH; all other codes invalid.
- `req_data_in` in 32: operand 1 in the command cycle, operand 2 in the following cycle.
- `out_resp` out 2: 0 none, 1 success, 2 overflow/underflow/invalid command, 3 never driven.
- `out_data` out 32: result; valid only while `out_resp`≠0.
- `req_drop` out 1: one-cycle pulse when a completed request is discarded because the FIFO is full.

## Operation
- Capture FSM:
  - IDLE: a non-NOP `req_cmd_in` latches cmd and operand 1 and moves to OPND2.
  - OPND2: unconditionally latches `req_data_in` as operand 2, pushes {cmd, op1, op2} into the FIFO and returns to IDLE.
  - `req_cmd_in` is ignored in OPND2, so a command issued there is lost by design.
- FIFO full at push: the request is discarded and `req_drop` pulses; FIFO contents are unchanged.
- Execute stage pops at most one entry per cycle when the FIFO is non-empty and registers the response.
- ADD: 33-bit sum. Carry out of bit 31 gives resp 2, data 0; otherwise resp 1, data = sum[31:0].
- SUB: op2 > op1 (unsigned) gives resp 2, data 0; otherwise resp 1, data = op1 − op2. Equal operands give resp 1, data 0.
- LSH/RSH: logical shift of op1 by op2[4:0] only; upper bits of op2 are ignored. Zero fill, resp 1.
  - Shift by 32 acts as shift 0, e.g. 0xFFFFFFFF LSH 32 → 0xFFFFFFFF.
  - 0xFFFFFFFF RSH 0xFFFFFFFF → 0x00000001.
- Invalid command: resp 2, data 0; the command is still consumed as a two-cycle request.
- Outputs return to 0 the cycle after a response.

## Timing
- Reset values: FSM IDLE, FIFO empty, `out_resp`=0, `out_data`=0, `req_drop`=0. Reset asserted mid-request or mid-queue discards everything with no response.
- Latency with an empty FIFO:
  - Command at edge T, operand 2 at T+1, push at T+1.
  - Pop and execute at T+2; `out_resp`/`out_data` valid for exactly the cycle after edge T+2.
- Back-to-back requests (command every 2 cycles) sustain one response per 2 cycles with no drops.
- Simultaneous push and pop when the FIFO is full: the pop frees the slot first, so the push succeeds and no drop occurs.
- Simultaneous push and pop when the FIFO is empty: the request does not bypass the FIFO; the pop sees the pre-push state.
- Pointer wrap: pointers are log2(FIFO_DEPTH)+1 bits; full/empty are derived from the MSB comparison.

## Configuration
- `CALC1_SHIFT_EN` defined: LSH/RSH execute as described.
- `CALC1_SHIFT_EN` undefined: the shifter is removed, and codes 5 and 6 are treated as invalid (resp 2, data 0).
- Capture, queueing and timing are identical in both builds.

## Structure
- Shared package `calc1_pkg`:
  - command codes CMD_NOP/ADD/SUB/LSH/RSH;
  - response codes RESP_NONE/OK/ERR;
  - request struct {cmd[3:0], op1[31:0], op2[31:0]}.
- Sub-module `calc1_req_fifo` (synchronous, parameterised depth, push/pop/full/empty, same async active-low reset).
- Capture FSM and execute/ALU stay in the top module.

## Test plan
- Reset then ADD 0xFFFF0000 + 0x0000FFFF: resp 1, data 0xFFFFFFFF, exactly 2 cycles after the operand-2 cycle.
- ADD 0xFFFFFFFF + 0x00000001: resp 2, data 0. SUB 0x00000000 − 0x00000001: resp 2. SUB 0xFFFF0000 − 0x0000FFFF: resp 1, data 0xFFFE0001.
- LSH 0x0F0F0F0F by 4 → 0xF0F0F0F0. RSH 0x80000000 by 31 → 0x00000001. LSH 0x00000001 by 32 → 0x00000001.
  - Without `CALC1_SHIFT_EN`, each of these returns resp 2.
- Invalid cmd 3 with operands 0x1234, 0x5678: resp 2, data 0, one response only; the following ADD 1 + 1 returns 0x00000002.
- Stress: issue requests every 2 cycles while output consumption is unconstrained; confirm no `req_drop` and responses in issue order. Force FIFO_DEPTH=2 with a stalled-pop testpoint and verify `req_drop` on the third push.
- Deassert `reset` between the command and operand-2 cycles: no response, no drop; the next ADD 2 + 3 returns 0x00000005.
